l1_d_controller: RTL and testbench

Direct-mapped L1 data-cache controller that sequences the L1 data array for CPU loads and stores. Holds the tag/valid/dirty state, decides hit or miss, and drives the data-array control pins (`index`, `offset`, `update_L1`, `refill_L1`). On a miss it performs a dirty-victim writeback to L2, then a block fetch from L2. Sits between the CPU load/store unit, `L1_D_data_array` and the L2 request port.

---
 rtl/l1_d_controller.sv | 183 ++++++++++++++++++
 tb/tb_l1_d_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_d_controller.sv
// l1_d_controller: direct-mapped L1 data-cache controller.
//
// Keeps the per-set tag/valid/dirty state and decides hit or miss. It drives the
// control pins of the L1 data array and sequences dirty-victim writebacks and
// block fetches over the L2 request port.
//
// Optional feature: define L1D_PERF_CNT_EN to add the hit_count/miss_count ports.
//
// Ports:
//   clk, nrst             clock (rising edge), asynchronous active-low reset
//   cpu_req/cpu_we/addr   CPU request valid, store select, byte address
//   stall_L1              CPU must hold; request not accepted this cycle
//   cpu_done              one-cycle pulse when the access completes
//   index/offset          data-array set select and byte offset (latched address)
//   update_L1/refill_L1   data-array store-hit strobe / block-refill strobe
//   L2_rd/L2_wr/L2_addr   L2 block read, victim writeback, block-aligned address
//   L2_ready              L2 completes the current request this cycle
//   hit_count/miss_count  (L1D_PERF_CNT_EN only) wrapping lookup counters
module l1_d_controller #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned OFFSET_W = 6
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                L2_ready,
    output logic                stall_L1,
    output logic                cpu_done,
    output logic [INDEX_W-1:0]  index,
    output logic [OFFSET_W-1:0] offset,
    output logic                update_L1,
    output logic                refill_L1,
    output logic                L2_rd,
    output logic                L2_wr,
    output logic [ADDR_W-1:0]   L2_addr
`ifdef L1D_PERF_CNT_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned NUM_SETS = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWriteback,
        StAllocate,
        StRefill
    } state_e;

    state_e                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  we_q;
    logic [NUM_SETS-1:0]   valid_q;
    logic [NUM_SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]      tag_q [NUM_SETS];

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_index;
    logic                  hit;
    logic                  victim_dirty;

    assign req_tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign req_index    = addr_q[OFFSET_W +: INDEX_W];
    assign hit          = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign victim_dirty = valid_q[req_index] && dirty_q[req_index];

    // Request latch, FSM and per-set valid/dirty bits.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        state_q <= StCompare;
                    end
                end
                StCompare: begin
                    if (hit) begin
                        if (we_q) dirty_q[req_index] <= 1'b1;
                        state_q <= StIdle;
                    end else if (victim_dirty) begin
                        state_q <= StWriteback;
                    end else begin
                        state_q <= StAllocate;
                    end
                end
                StWriteback: begin
                    if (L2_ready) begin
                        dirty_q[req_index] <= 1'b0;
                        state_q            <= StAllocate;
                    end
                end
                StAllocate: begin
                    if (L2_ready) state_q <= StRefill;
                end
                StRefill: begin
                    valid_q[req_index] <= 1'b1;
                    dirty_q[req_index] <= 1'b0;
                    state_q            <= StCompare;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tags need no reset: they are only consulted while the valid bit is set.
    always_ff @(posedge clk) begin
        if (state_q == StRefill) tag_q[req_index] <= req_tag;
    end

    // All outputs decode registered state only, so strobes are clean single cycles.
    always_comb begin
        stall_L1  = 1'b1;
        cpu_done  = 1'b0;
        update_L1 = 1'b0;
        refill_L1 = 1'b0;
        L2_rd     = 1'b0;
        L2_wr     = 1'b0;
        L2_addr   = '0;
        unique case (state_q)
            StIdle: stall_L1 = 1'b0;
            StCompare: begin
                if (hit) begin
                    stall_L1  = 1'b0;
                    cpu_done  = 1'b1;
                    update_L1 = we_q;
                end
            end
            StWriteback: begin
                L2_wr   = 1'b1;
                L2_addr = {tag_q[req_index], req_index, {OFFSET_W{1'b0}}};
            end
            StAllocate: begin
                L2_rd   = 1'b1;
                L2_addr = {req_tag, req_index, {OFFSET_W{1'b0}}};
            end
            StRefill: refill_L1 = 1'b1;
            default: stall_L1 = 1'b1;
        endcase
    end

    assign index  = req_index;
    assign offset = addr_q[OFFSET_W-1:0];

`ifdef L1D_PERF_CNT_EN
    // relookup_q marks the COMPARE that follows REFILL; that hit is not a CPU hit.
    logic        relookup_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            relookup_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            relookup_q <= (state_q == StRefill);
            if (state_q == StCompare) begin
                if (!hit)             miss_cnt_q <= miss_cnt_q + 32'd1;
                else if (!relookup_q) hit_cnt_q  <= hit_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_d_controller.sv
// Self-checking bench for l1_d_controller: a reference cache model pushes the
// expected outcome of each request to a scoreboard queue; the entry is popped
// and compared when the DUT signals completion.
module tb_l1_d_controller;

    logic        clk;
    logic        nrst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic        L2_ready;
    logic        stall_L1;
    logic        cpu_done;
    logic [5:0]  index;
    logic [5:0]  offset;
    logic        update_L1;
    logic        refill_L1;
    logic        L2_rd;
    logic        L2_wr;
    logic [31:0] L2_addr;
`ifdef L1D_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    l1_d_controller u_dut (
        .clk       (clk),
        .nrst      (nrst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .L2_ready  (L2_ready),
        .stall_L1  (stall_L1),
        .cpu_done  (cpu_done),
        .index     (index),
        .offset    (offset),
        .update_L1 (update_L1),
        .refill_L1 (refill_L1),
        .L2_rd     (L2_rd),
        .L2_wr     (L2_wr),
        .L2_addr   (L2_addr)
`ifdef L1D_PERF_CNT_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        int          lat;
        logic [31:0] wr_addr;
        logic [31:0] rd_addr;
        int          n_upd;
        int          n_refill;
    } exp_t;

    exp_t        sb[$];
    int          n_vec;
    int          n_err;

    // Reference cache state.
    logic        m_valid [64];
    logic        m_dirty [64];
    logic [19:0] m_tag   [64];
    int          m_hits;
    int          m_misses;

    // L2 responder state.
    int          l2_lat;
    logic        l2_always;
    int          busy_cnt;
    logic        prev_rd;
    logic        prev_wr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then answer L2 based on how long the
    // current request has been visible.
    task automatic tick();
        @(negedge clk);
        if (L2_rd || L2_wr) begin
            if (L2_rd == prev_rd && L2_wr == prev_wr) busy_cnt++;
            else busy_cnt = 1;
        end else begin
            busy_cnt = 0;
        end
        prev_rd  = L2_rd;
        prev_wr  = L2_wr;
        L2_ready = l2_always || ((L2_rd || L2_wr) && busy_cnt > l2_lat);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
    endtask

    task automatic run_req(input logic [31:0] addr, input logic we, input int lat);
        exp_t        e;
        exp_t        got;
        int          idx;
        logic [19:0] tg;
        logic        dirty;
        int          n;
        int          n_stall;
        int          both;
        logic        done;
        logic [5:0]  upd_off;
        logic [5:0]  done_idx;

        idx        = int'(addr[11:6]);
        tg         = addr[31:12];
        e.addr     = addr;
        e.we       = we;
        e.wr_addr  = '0;
        e.rd_addr  = '0;
        e.n_upd    = we ? 1 : 0;
        e.n_refill = 0;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            e.lat = 1;
            m_hits++;
        end else begin
            dirty      = m_valid[idx] && m_dirty[idx];
            e.wr_addr  = dirty ? {m_tag[idx], addr[11:6], 6'b0} : 32'h0;
            e.rd_addr  = {tg, addr[11:6], 6'b0};
            e.lat      = 4 + lat + (dirty ? lat + 1 : 0);
            e.n_refill = 1;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_misses++;
        end
        if (we) m_dirty[idx] = 1'b1;
        sb.push_back(e);

        l2_lat = lat;
        tick();
        cpu_req  = 1'b1;
        cpu_addr = addr;
        cpu_we   = we;
        n        = 0;
        n_stall  = 0;
        both     = 0;
        done     = 1'b0;
        upd_off  = '0;
        done_idx = '0;
        got      = '{addr: addr, we: we, lat: 0, wr_addr: 0, rd_addr: 0, n_upd: 0, n_refill: 0};
        while (!done && n < 100) begin
            tick();
            n++;
            if (L2_wr && got.wr_addr == 0) got.wr_addr = L2_addr;
            if (L2_rd && got.rd_addr == 0) got.rd_addr = L2_addr;
            if (update_L1) begin
                got.n_upd++;
                upd_off = offset;
            end
            if (refill_L1) got.n_refill++;
            if ((L2_rd && L2_wr) || (update_L1 && refill_L1)) both++;
            if (stall_L1) n_stall++;
            if (cpu_done) begin
                done     = 1'b1;
                done_idx = index;
            end
            // Scramble the request pins: the latched request must be unaffected.
            if (n == 1) begin
                cpu_req  = 1'b0;
                cpu_addr = $urandom();
                cpu_we   = 1'($urandom_range(0, 1));
            end
        end
        got.lat = n;

        e = sb.pop_front();
        check("latency", 64'(got.lat), 64'(e.lat));
        check("stall_cycles", 64'(n_stall), 64'(e.lat - 1));
        check("l2_wr_addr", 64'(got.wr_addr), 64'(e.wr_addr));
        check("l2_rd_addr", 64'(got.rd_addr), 64'(e.rd_addr));
        check("update_pulses", 64'(got.n_upd), 64'(e.n_upd));
        check("update_offset", 64'(upd_off), e.we ? 64'(e.addr[5:0]) : 64'h0);
        check("refill_pulses", 64'(got.n_refill), 64'(e.n_refill));
        check("done_index", 64'(done_idx), 64'(e.addr[11:6]));
        check("exclusive_strobes", 64'(both), 64'h0);
    endtask

    initial begin
        int   n;
        int   cnt;
        logic seen;

        n_vec     = 0;
        n_err     = 0;
        m_hits    = 0;
        m_misses  = 0;
        l2_lat    = 0;
        l2_always = 1'b0;
        busy_cnt  = 0;
        prev_rd   = 1'b0;
        prev_wr   = 1'b0;
        nrst      = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        L2_ready  = 1'b0;
        model_clear();

        repeat (2) @(negedge clk);
        check("reset_outputs",
              64'({stall_L1, cpu_done, update_L1, refill_L1, L2_rd, L2_wr, index, offset, L2_addr}),
              64'h0);
`ifdef L1D_PERF_CNT_EN
        check("reset_counters", {hit_count, miss_count}, 64'h0);
`endif
        nrst = 1'b1;

        run_req(32'h0000_1040, 1'b0, 3);   // cold miss, L2 answers 3 cycles after L2_rd
        run_req(32'h0000_1040, 1'b0, 0);   // load hit
        run_req(32'h0000_1044, 1'b1, 0);   // store hit, offset 4, line becomes dirty
        run_req(32'h0000_2040, 1'b0, 2);   // same set, new tag: writeback then fetch
`ifdef L1D_PERF_CNT_EN
        check("hit_count", 64'(hit_count), 64'(m_hits));
        check("miss_count", 64'(miss_count), 64'(m_misses));
`endif
        run_req(32'h0000_2048, 1'b1, 0);   // dirty the line again

        l2_always = 1'b1;
        run_req(32'h0000_1040, 1'b0, 0);   // dirty miss with L2 always ready
        run_req(32'h0000_50C0, 1'b1, 0);   // clean store miss
        run_req(32'h0000_50C0, 1'b0, 0);   // hit on the just-stored line
        l2_alwayswait_fix: begin end
        l2_always = 1'b0;
        run_req(32'h0000_1048, 1'b1, 1);   // dirty set 1 before the reset test

        // Reset while waiting in ALLOCATE.
        l2_lat = 10;
        tick();
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_3080;
        cpu_we   = 1'b0;
        n        = 0;
        seen     = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (n == 1) cpu_req = 1'b0;
            if (L2_rd) seen = 1'b1;
        end
        check("alloc_reached", 64'(seen), 64'h1);
        nrst = 1'b0;
        #1;
        check("reset_midop_outputs",
              64'({stall_L1, cpu_done, update_L1, refill_L1, L2_rd, L2_wr, index, offset, L2_addr}),
              64'h0);
`ifdef L1D_PERF_CNT_EN
        check("reset_midop_counters", {hit_count, miss_count}, 64'h0);
        m_hits   = 0;
        m_misses = 0;
`endif
        model_clear();
        tick();
        nrst = 1'b1;

        run_req(32'h0000_3080, 1'b0, 1);   // misses again after reset
        run_req(32'h0000_1040, 1'b0, 1);   // was dirty before reset: no writeback

        // Held request on a hitting line completes every other cycle.
        tick();
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_1040;
        cpu_we   = 1'b0;
        cnt      = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cpu_done) cnt++;
        end
        cpu_req = 1'b0;
        m_hits += 4;
        check("back_to_back_done", 64'(cnt), 64'h4);
        tick();
        tick();
`ifdef L1D_PERF_CNT_EN
        check("hit_count_final", 64'(hit_count), 64'(m_hits));
        check("miss_count_final", 64'(miss_count), 64'(m_misses));
`endif
        check("final_idle", 64'({stall_L1, L2_rd, L2_wr}), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
